// File: rtl/muxcont_rr.sv
// muxcont_rr: round-robin contention controller for one router output; holds grant for a whole packet.
// Latency: request to grt 0 cycles (combinational); grt to sel 1 cycle; no bubble between packets.
// Backpressure: grants gated by ready; a stalled lock is force-released after TIMEOUT idle cycles.
//
// Ports:
//   clk, rst_          clock (rising edge), asynchronous active-high reset
//   port               destination id per channel, channel i at [i*PORTW +: PORTW]
//   req/multab/tail    per-channel flit valid, multicast/absorb flag, last-flit flag
//   ready              downstream accepts a flit this cycle
//   grt                one-hot combinational grant (flit transfers this cycle)
//   sel                grt registered, drives the crossbar select
//   multab_ct          eligible multicast/absorb requests that lost this cycle
//   busy, abort        registered: in LOCK next cycle / one-cycle timeout-release pulse
module muxcont_rr #(
   parameter int NPORT   = 5,
   parameter int PORTW   = 3,
   parameter int PORTID  = 0,
   parameter int TIMEOUT = 15
) (
   input  logic                   clk,
   input  logic                   rst_,
   input  logic [NPORT*PORTW-1:0] port,
   input  logic [NPORT-1:0]       req,
   input  logic [NPORT-1:0]       multab,
   input  logic [NPORT-1:0]       tail,
   input  logic                   ready,
   output logic [NPORT-1:0]       grt,
   output logic [NPORT-1:0]       sel,
   output logic [NPORT-1:0]       multab_ct,
   output logic                   busy,
   output logic                   abort
);

   localparam int PW = $clog2(NPORT);
   localparam int HW = $clog2(TIMEOUT + 1);

   typedef enum logic {IDLE, LOCK} state_t;

   state_t           state;
   logic [PW-1:0]    ptr;
   logic [PW-1:0]    owner;
   logic [HW-1:0]    hcnt;
   logic [NPORT-1:0] elig;
   logic [PW-1:0]    win;
   logic             win_vld;
   logic             own_xfer;
   int               idx;

   // Next channel after p, wrapping at NPORT-1 (NPORT need not be a power of two).
   function automatic logic [PW-1:0] inc_wrap(input logic [PW-1:0] p);
      if (p == PW'(NPORT - 1))
         return '0;
      return p + 1'b1;
   endfunction

   always_comb begin
      elig = '0;
      for (int i = 0; i < NPORT; i++)
         elig[i] = req[i] & (multab[i] | (port[i*PORTW +: PORTW] == PORTW'(PORTID)));
   end

   // Round-robin scan starting at ptr; first eligible channel wins.
   always_comb begin
      win_vld = 1'b0;
      win     = '0;
      idx     = 0;
      for (int k = 0; k < NPORT; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NPORT)
            idx = idx - NPORT;
         if (!win_vld && elig[idx]) begin
            win_vld = 1'b1;
            win     = PW'(idx);
         end
      end
   end

   // The owner's body flits are not re-checked for eligibility.
   assign own_xfer = req[owner] & ready;

   always_comb begin
      grt = '0;
      if (state == IDLE) begin
         if (ready && win_vld)
            grt[win] = 1'b1;
      end else if (own_xfer) begin
         grt[owner] = 1'b1;
      end
   end

   // Evaluated in every state so multicast requests blocked by a lock are flagged each cycle.
   assign multab_ct = elig & multab & ~grt;

   always_ff @(posedge clk or posedge rst_) begin
      if (rst_) begin
         state <= IDLE;
         ptr   <= '0;
         owner <= '0;
         hcnt  <= '0;
         sel   <= '0;
         busy  <= 1'b0;
         abort <= 1'b0;
      end else begin
         sel   <= grt;
         abort <= 1'b0;
         busy  <= 1'b0;
         case (state)
            IDLE: begin
               if (ready && win_vld) begin
                  if (tail[win]) begin
                     ptr <= inc_wrap(win);
                  end else begin
                     state <= LOCK;
                     owner <= win;
                     hcnt  <= '0;
                     busy  <= 1'b1;
                  end
               end
            end
            LOCK: begin
               if (own_xfer) begin
                  hcnt <= '0;
                  // A tail transfer wins over a coincident timeout: normal release.
                  if (tail[owner]) begin
                     state <= IDLE;
                     ptr   <= inc_wrap(owner);
                  end else begin
                     busy <= 1'b1;
                  end
               end else if (hcnt == HW'(TIMEOUT - 1)) begin
                  state <= IDLE;
                  ptr   <= inc_wrap(owner);
                  hcnt  <= '0;
                  abort <= 1'b1;
               end else begin
                  hcnt <= hcnt + 1'b1;
                  busy <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muxcont_rr.sv
module tb_muxcont_rr;

   localparam int NPORT = 5;
   localparam int PORTW = 3;

   logic                   clk = 1'b0;
   logic                   rst_;
   logic [NPORT*PORTW-1:0] port;
   logic [NPORT-1:0]       req, multab, tail;
   logic                   ready;
   logic [NPORT-1:0]       grt, sel, multab_ct;
   logic                   busy, abort;

   int checks = 0;
   int errors = 0;

   muxcont_rr #(.NPORT(5), .PORTW(3), .PORTID(0), .TIMEOUT(4)) dut (
      .clk(clk), .rst_(rst_), .port(port), .req(req), .multab(multab), .tail(tail),
      .ready(ready), .grt(grt), .sel(sel), .multab_ct(multab_ct), .busy(busy), .abort(abort)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Apply inputs after a falling edge; outputs are sampled 1 time unit later.
   task automatic drive(input logic [4:0] r, input logic [4:0] t, input logic [4:0] m, input logic rdy);
      @(negedge clk);
      req = r; tail = t; multab = m; ready = rdy;
      #1;
   endtask

   initial begin
      rst_ = 1'b1; port = '0; req = '0; multab = '0; tail = '0; ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_sel",   8'(sel), 8'b0);
      chk("rst_busy",  8'(busy), 8'b0);
      chk("rst_abort", 8'(abort), 8'b0);
      chk("rst_grt",   8'(grt), 8'b0);
      @(negedge clk); rst_ = 1'b0;

      // Two single-flit packets on channels 1 and 2.
      drive(5'b00110, 5'b00110, 5'b0, 1'b1);
      chk("rr_grt0", 8'(grt), 8'b00010);
      chk("rr_sel0", 8'(sel), 8'b00000);
      drive(5'b00100, 5'b00100, 5'b0, 1'b1);
      chk("rr_grt1", 8'(grt), 8'b00100);
      chk("rr_sel1", 8'(sel), 8'b00010);
      // ptr=3: channel 4 beats channel 0, then ptr wraps to 0.
      drive(5'b10001, 5'b10000, 5'b0, 1'b1);
      chk("ptr3_grt", 8'(grt), 8'b10000);
      chk("ptr3_sel", 8'(sel), 8'b00100);

      // Channel 0 three-flit packet vs continuous channel 4.
      drive(5'b10001, 5'b10000, 5'b0, 1'b1);
      chk("pkt_grt0", 8'(grt), 8'b00001);
      chk("pkt_busy0", 8'(busy), 8'b0);
      drive(5'b10001, 5'b10000, 5'b0, 1'b1);
      chk("pkt_grt1", 8'(grt), 8'b00001);
      chk("pkt_busy1", 8'(busy), 8'b1);
      chk("pkt_sel1", 8'(sel), 8'b00001);
      drive(5'b10001, 5'b10001, 5'b0, 1'b1);
      chk("pkt_grt2", 8'(grt), 8'b00001);
      chk("pkt_busy2", 8'(busy), 8'b1);
      drive(5'b10000, 5'b10000, 5'b0, 1'b1);
      chk("pkt_grt3", 8'(grt), 8'b10000);
      chk("pkt_busy3", 8'(busy), 8'b0);
      drive(5'b0, 5'b0, 5'b0, 1'b1);
      chk("pkt_idle", 8'(grt), 8'b0);
      chk("pkt_sel3", 8'(sel), 8'b10000);

      // Lock on channel 2 with ready low for two cycles.
      drive(5'b00100, 5'b0, 5'b0, 1'b1);
      chk("stl_grt0", 8'(grt), 8'b00100);
      drive(5'b00100, 5'b0, 5'b0, 1'b0);
      chk("stl_grt1", 8'(grt), 8'b0);
      chk("stl_busy1", 8'(busy), 8'b1);
      drive(5'b00100, 5'b0, 5'b0, 1'b0);
      chk("stl_grt2", 8'(grt), 8'b0);
      chk("stl_busy2", 8'(busy), 8'b1);
      chk("stl_abort2", 8'(abort), 8'b0);
      drive(5'b00100, 5'b00100, 5'b0, 1'b1);
      chk("stl_grt3", 8'(grt), 8'b00100);
      chk("stl_abort3", 8'(abort), 8'b0);
      drive(5'b0, 5'b0, 5'b0, 1'b1);
      chk("stl_busy4", 8'(busy), 8'b0);

      // Timeout: channel 3 sends its head then goes silent (ptr=3).
      drive(5'b01000, 5'b0, 5'b0, 1'b1);
      chk("to_grt0", 8'(grt), 8'b01000);
      for (int c = 0; c < 4; c++) begin
         drive(5'b0, 5'b0, 5'b0, 1'b1);
         chk($sformatf("to_idle_grt%0d", c), 8'(grt), 8'b0);
         chk($sformatf("to_idle_busy%0d", c), 8'(busy), 8'b1);
         chk($sformatf("to_idle_abort%0d", c), 8'(abort), 8'b0);
      end
      // Released with ptr=4: channel 4 beats channel 0.
      drive(5'b10001, 5'b10001, 5'b0, 1'b1);
      chk("to_abort", 8'(abort), 8'b1);
      chk("to_busy", 8'(busy), 8'b0);
      chk("to_ptr4_grt", 8'(grt), 8'b10000);
      drive(5'b0, 5'b0, 5'b0, 1'b1);
      chk("to_abort_end", 8'(abort), 8'b0);

      // Multicast channel 1 (port 3) blocked by channel 0 lock (ptr=0).
      port[1*PORTW +: PORTW] = 3'd3;
      drive(5'b00001, 5'b0, 5'b0, 1'b1);
      chk("mc_grt0", 8'(grt), 8'b00001);
      chk("mc_ct0", 8'(multab_ct), 8'b0);
      drive(5'b00011, 5'b0, 5'b00010, 1'b1);
      chk("mc_grt1", 8'(grt), 8'b00001);
      chk("mc_ct1", 8'(multab_ct), 8'b00010);
      drive(5'b00011, 5'b00001, 5'b00010, 1'b1);
      chk("mc_grt2", 8'(grt), 8'b00001);
      chk("mc_ct2", 8'(multab_ct), 8'b00010);
      drive(5'b00010, 5'b00010, 5'b00010, 1'b1);
      chk("mc_grt3", 8'(grt), 8'b00010);
      chk("mc_ct3", 8'(multab_ct), 8'b0);
      // Same channel without multab targets port 3: not eligible.
      drive(5'b00010, 5'b00010, 5'b0, 1'b1);
      chk("mc_inelig", 8'(grt), 8'b0);
      port[1*PORTW +: PORTW] = 3'd0;

      // Reset during a lock on channel 4 (ptr=2).
      drive(5'b10000, 5'b0, 5'b0, 1'b1);
      chk("rl_grt0", 8'(grt), 8'b10000);
      drive(5'b10000, 5'b0, 5'b0, 1'b1);
      chk("rl_busy1", 8'(busy), 8'b1);
      chk("rl_sel1", 8'(sel), 8'b10000);
      #2 rst_ = 1'b1;
      #1;
      chk("rl_busy_async", 8'(busy), 8'b0);
      chk("rl_sel_async", 8'(sel), 8'b0);
      req = '0;
      @(negedge clk); rst_ = 1'b0;
      drive(5'b10001, 5'b10001, 5'b0, 1'b1);
      chk("rl_prio0", 8'(grt), 8'b00001);

      // Tail transfer exactly at hcnt = TIMEOUT-1: normal release (ptr=1 -> channel 0 via wrap? no: 0 only requester).
      drive(5'b00001, 5'b0, 5'b0, 1'b1);
      chk("tt_grt0", 8'(grt), 8'b00001);
      repeat (3) drive(5'b00001, 5'b0, 5'b0, 1'b0);
      chk("tt_stall", 8'(grt), 8'b0);
      drive(5'b00001, 5'b00001, 5'b0, 1'b1);
      chk("tt_grt_tail", 8'(grt), 8'b00001);
      drive(5'b0, 5'b0, 5'b0, 1'b1);
      chk("tt_abort", 8'(abort), 8'b0);
      chk("tt_busy", 8'(busy), 8'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
